pcie_rx_block_decoder: RTL
==========================

// Module: pcie_rx_block_decoder
// PURPOSE
//  Per-lane Gen3/Gen4 128b/130b receive decoder, placed between the lane deserializer and the PCS.
//  Acquires block alignment from the 2-bit sync headers and requests PMA bit-slips while unaligned.
//  Descrambles data blocks, strips SKP ordered sets, and buffers blocks for a ready/valid consumer.
// PARAMETERS
//  LOCK_CNT     4          consecutive valid headers needed to declare lock (1..15)
//  LOSS_CNT     4          consecutive invalid headers that drop lock (1..15)
//  SLIP_WAIT    8          clk_phy cycles of slip blanking after each rx_slip pulse (1..255)
//  FIFO_DEPTH   4          output FIFO entries, power of two >= 2
//  LANE_SEED    23'h1DBFBC descrambler LFSR seed for this lane
// PORTS
//  clk_phy         in   1    PHY clock
//  rst_n_phy       in   1    synchronous active-low reset
//  rx_blk_valid    in   1    rx_blk_data holds a new 130-bit block (no backpressure possible)
//  rx_blk_data     in   130  [129:128] sync header, [127:0] payload, bit 0 = first on the wire
//  rx_slip         out  1    one-cycle request to the deserializer to shift its boundary by one bit
//  dec_valid       out  1    FIFO head is valid
//  dec_ready       in   1    consumer accepts the head when dec_valid&&dec_ready
//  dec_data        out  128  descrambled data payload, or raw ordered-set payload
//  dec_is_os       out  1    1 = ordered-set block, 0 = data block
//  blk_locked      out  1    block alignment achieved
//  hdr_err         out  1    one-cycle pulse per invalid header received while locked
//  fifo_ovf        out  1    one-cycle pulse when an incoming block is dropped because the FIFO is full
//  hdr_err_cnt     out  16   saturating count of invalid headers (PCIE_RX_ERR_CNT_EN only)
// BEHAVIOUR
//  Reset: all outputs 0; FSM in UNALIGNED; LFSR=LANE_SEED; FIFO empty; all counters 0.
//  Header 2'b10 = data, 2'b01 = ordered set, 2'b00 and 2'b11 = invalid. Only cycles with rx_blk_valid=1 count.
//  FSM UNALIGNED: valid hdr -> good_cnt+1, enter ALIGNED when good_cnt reaches LOCK_CNT.
//    Invalid hdr with blanking counter 0 -> rx_slip=1 next cycle, good_cnt=0, blanking=SLIP_WAIT.
//    Invalid hdr during blanking -> good_cnt=0, no slip. Blanking decrements every cycle.
//  FSM ALIGNED: blk_locked=1. Invalid hdr -> hdr_err pulse, bad_cnt+1, block discarded.
//    bad_cnt reaching LOSS_CNT -> UNALIGNED, LFSR=LANE_SEED. Any valid hdr clears bad_cnt.
//  Blocks are forwarded only in ALIGNED; the block that completes lock is the first forwarded.
//  OS identifier = payload[7:0]. SKP=8'hAA, EIEOS=payload {8{16'hFF00}}.
//  SKP blocks: dropped; LFSR holds.
//  EIEOS blocks: forwarded; LFSR reloads LANE_SEED after the block.
//  Other OS blocks: forwarded raw, not descrambled; LFSR advances 128 steps.
//  Data blocks: payload XORed bit-serially (bit 0 first) with LFSR x^23+x^21+x^16+x^8+x^5+x^2+1;
//    LFSR advances 128 steps.
//  Latency: decode/descramble register stage (1 cycle), then FIFO write. dec_valid rises 2 cycles
//    after a rx_blk_valid sample when the FIFO is empty. FIFO is show-ahead.
//  FIFO full with an incoming block and no pop in the same cycle -> block dropped, fifo_ovf pulse,
//    LFSR still advances. Full with push and pop in the same cycle -> both succeed.
//  Pointers wrap modulo FIFO_DEPTH; one extra bit distinguishes full from empty.
//  Reset asserted mid-stream discards FIFO contents and alignment state in the same cycle.
// CONFIGURATION
//  PCIE_RX_ERR_CNT_EN defined: hdr_err_cnt port exists. It increments on every invalid header
//    (locked or not), saturates at 16'hFFFF, and clears only on reset.
//  PCIE_RX_ERR_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  pcie_phy_pkg holds: sync-header constants, OS identifier constants (SKP, EIEOS, TS1=8'h1E,
//    TS2=8'h2D, SDS=8'hE1), the default LFSR seed, the polynomial tap mask, and align_state_t.
//  Sub-module pcie_rx_descrambler: combinational 128-step LFSR advance plus XOR
//    (inputs: lfsr, data, enable; outputs: data, next lfsr).
//  FIFO stays inline.
// TESTING
//  1) Four valid 2'b10 headers from reset -> blk_locked=1 after the 4th; the 4th block appears
//     on dec_data 2 cycles later.
//  2) Unaligned, header 2'b00 -> rx_slip pulses once. Three more bad headers within 8 cycles ->
//     no further slip; next bad header after blanking -> slip.
//  3) Locked, SKP block (payload[7:0]=8'hAA) then data block -> SKP absent from output, data
//     matches the golden descrambler with the LFSR unadvanced.
//  4) Locked, EIEOS then data block of all zeros -> output equals the LANE_SEED keystream.
//  5) dec_ready=0, 5 blocks -> 4 held, fifo_ovf on the 5th. Raise dec_ready -> blocks 1-4 in order.
//  6) Locked: 3 bad headers, 1 good, 3 bad -> still locked, 6 hdr_err pulses.
//     A 4th consecutive bad header -> blk_locked=0.
//     With PCIE_RX_ERR_CNT_EN defined, hdr_err_cnt=7 at that point.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY constants and types for the 128b/130b receive path.
package pcie_phy_pkg;

    localparam logic [1:0]   SYNC_DATA = 2'b10;
    localparam logic [1:0]   SYNC_OS   = 2'b01;

    localparam logic [7:0]   OS_SKP    = 8'hAA;
    localparam logic [7:0]   OS_EIEOS  = 8'h00;
    localparam logic [7:0]   OS_TS1    = 8'h1E;
    localparam logic [7:0]   OS_TS2    = 8'h2D;
    localparam logic [7:0]   OS_SDS    = 8'hE1;
    localparam logic [127:0] EIEOS_PAYLOAD = {8{16'hFF00}};

    localparam logic [22:0]  DEFAULT_LANE_SEED = 23'h1DBFBC;
    // x^23+x^21+x^16+x^8+x^5+x^2+1, Galois form: bits 21,16,8,5,2,0
    localparam logic [22:0]  LFSR_TAPS = 23'h210125;

    typedef enum logic {
        UNALIGNED = 1'b0,
        ALIGNED   = 1'b1
    } align_state_t;

    typedef struct packed {
        logic         is_os;
        logic [127:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pcie_rx_descrambler.sv
// Combinational 128-step descrambler: keystream bit is lfsr[22] before each step, bit 0 first.
module pcie_rx_descrambler
    import pcie_phy_pkg::*;
(
    input  logic [22:0]  lfsr,
    input  logic [127:0] data_in,
    input  logic         enable,
    output logic [127:0] data_out,
    output logic [22:0]  lfsr_next
);

    always_comb begin
        logic [22:0] s;
        s        = lfsr;
        data_out = data_in;
        for (int i = 0; i < 128; i++) begin
            if (enable)
                data_out[i] = data_in[i] ^ s[22];
            s = {s[21:0], 1'b0} ^ (s[22] ? LFSR_TAPS : 23'd0);
        end
        lfsr_next = s;
    end

endmodule

// File: rtl/pcie_rx_block_decoder.sv
// Per-lane 128b/130b block aligner, descrambler and show-ahead output FIFO.
// Optional saturating invalid-header counter enabled by `define PCIE_RX_ERR_CNT_EN.
module pcie_rx_block_decoder
    import pcie_phy_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned LOSS_CNT   = 4,
    parameter int unsigned SLIP_WAIT  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [22:0] LANE_SEED  = DEFAULT_LANE_SEED
) (
    input  logic         clk_phy,
    input  logic         rst_n_phy,
    input  logic         rx_blk_valid,
    input  logic [129:0] rx_blk_data,
    output logic         rx_slip,
    output logic         dec_valid,
    input  logic         dec_ready,
    output logic [127:0] dec_data,
    output logic         dec_is_os,
    output logic         blk_locked,
    output logic         hdr_err,
    output logic         fifo_ovf
`ifdef PCIE_RX_ERR_CNT_EN
    ,
    output logic [15:0]  hdr_err_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    align_state_t state_q, state_d;
    logic [3:0]   good_q, good_d, bad_q, bad_d;
    logic [7:0]   blank_q, blank_d;
    logic [22:0]  lfsr_q, lfsr_d, lfsr_adv;
    logic         slip_d, hdr_err_d, fwd;

    logic [1:0]   hdr;
    logic [127:0] payload, desc_data;
    logic         hdr_ok, is_os, is_skp, is_eieos;

    assign hdr      = rx_blk_data[129:128];
    assign payload  = rx_blk_data[127:0];
    assign hdr_ok   = (hdr == SYNC_DATA) || (hdr == SYNC_OS);
    assign is_os    = (hdr == SYNC_OS);
    assign is_skp   = is_os && (payload[7:0] == OS_SKP);
    assign is_eieos = is_os && (payload == EIEOS_PAYLOAD);

    // Ordered sets pass through raw but still advance the LFSR.
    pcie_rx_descrambler u_desc (
        .lfsr      (lfsr_q),
        .data_in   (payload),
        .enable    (!is_os),
        .data_out  (desc_data),
        .lfsr_next (lfsr_adv)
    );

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        blank_d   = (blank_q != 8'd0) ? blank_q - 8'd1 : 8'd0;
        lfsr_d    = lfsr_q;
        slip_d    = 1'b0;
        hdr_err_d = 1'b0;
        fwd       = 1'b0;
        if (rx_blk_valid) begin
            case (state_q)
                UNALIGNED: begin
                    if (hdr_ok) begin
                        if (good_q + 4'd1 == 4'(LOCK_CNT)) begin
                            state_d = ALIGNED;
                            good_d  = 4'd0;
                            fwd     = 1'b1;
                        end else begin
                            good_d  = good_q + 4'd1;
                        end
                    end else begin
                        good_d = 4'd0;
                        if (blank_q == 8'd0) begin
                            slip_d  = 1'b1;
                            blank_d = 8'(SLIP_WAIT);
                        end
                    end
                end
                ALIGNED: begin
                    if (hdr_ok) begin
                        bad_d = 4'd0;
                        fwd   = 1'b1;
                    end else begin
                        hdr_err_d = 1'b1;
                        if (bad_q + 4'd1 == 4'(LOSS_CNT)) begin
                            state_d = UNALIGNED;
                            bad_d   = 4'd0;
                            lfsr_d  = LANE_SEED;
                        end else begin
                            bad_d   = bad_q + 4'd1;
                        end
                    end
                end
                default: state_d = UNALIGNED;
            endcase
        end
        if (fwd && !is_skp)
            lfsr_d = is_eieos ? LANE_SEED : lfsr_adv;
    end

    always_ff @(posedge clk_phy) begin
        if (!rst_n_phy) begin
            state_q <= UNALIGNED;
            good_q  <= 4'd0;
            bad_q   <= 4'd0;
            blank_q <= 8'd0;
            lfsr_q  <= LANE_SEED;
            rx_slip <= 1'b0;
            hdr_err <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            blank_q <= blank_d;
            lfsr_q  <= lfsr_d;
            rx_slip <= slip_d;
            hdr_err <= hdr_err_d;
        end
    end

    assign blk_locked = (state_q == ALIGNED);

    // Decode register stage feeding the FIFO write port.
    logic        s1_vld;
    fifo_entry_t s1_ent;

    always_ff @(posedge clk_phy) begin
        if (!rst_n_phy) begin
            s1_vld <= 1'b0;
            s1_ent <= '0;
        end else begin
            s1_vld       <= fwd && !is_skp;
            s1_ent.is_os <= is_os;
            s1_ent.data  <= desc_data;
        end
    end

    fifo_entry_t mem [FIFO_DEPTH];
    fifo_entry_t head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && dec_ready;
    assign push  = s1_vld && (!full || pop);

    always_ff @(posedge clk_phy) begin
        if (!rst_n_phy) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_ovf <= s1_vld && full && !pop;
        end
    end

    always_ff @(posedge clk_phy) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s1_ent;
    end

    // Gate the head so stale storage never reaches the outputs while empty.
    assign head      = mem[rd_ptr[AW-1:0]];
    assign dec_valid = !empty;
    assign dec_data  = dec_valid ? head.data : 128'd0;
    assign dec_is_os = dec_valid && head.is_os;

`ifdef PCIE_RX_ERR_CNT_EN
    always_ff @(posedge clk_phy) begin
        if (!rst_n_phy)
            hdr_err_cnt <= 16'd0;
        else if (rx_blk_valid && !hdr_ok && hdr_err_cnt != 16'hFFFF)
            hdr_err_cnt <= hdr_err_cnt + 16'd1;
    end
`endif

endmodule
